// File: rtl/bcd_display_counter_pkg.sv
// Shared types, segment constants and the digit-to-segment encoder for the
// BCD display counter.
package bcd_display_counter_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Non-decimal codes cannot occur in the count; they map to blank.
    function automatic seg_t seg_encode(input bcd_digit_t digit);
        case (digit)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_display_counter_if.sv
// Button inputs and display/count outputs of the BCD display counter.
// The master side owns the buttons; the slave side (the counter) owns the display.
interface bcd_display_counter_if
    import bcd_display_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                    btn_inc;
    logic                    btn_dec;
    logic                    btn_clr;
    seg_t                    seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [4*NUM_DIGITS-1:0] count_bcd;
    logic                    wrap;

    modport master (
        output btn_inc, btn_dec, btn_clr,
        input  seg, an, count_bcd, wrap
    );

    modport slave (
        input  btn_inc, btn_dec, btn_clr,
        output seg, an, count_bcd, wrap
    );
endinterface

// File: rtl/bcd_display_counter_btn_conditioner.sv
// Raw push-button conditioning: 2-flop synchroniser, debouncer that accepts a
// level only after DEBOUNCE_CYCLES consecutive differing samples, and a
// registered rising-edge detector giving one pulse per accepted press.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous pin into the clk domain.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two sync stages into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive cycles where the synced input differs from the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One-cycle pulse on each rising edge of the accepted level; releases are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign level       = r_level;
    assign press_pulse = r_press;

endmodule

// File: rtl/bcd_display_counter.sv
// Multi-digit BCD up/down counter driven by three debounced buttons, shown on a
// time-multiplexed common-anode 7-segment display with optional leading-zero blanking.
module bcd_display_counter
    import bcd_display_counter_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_CYCLES  = 100000,
    parameter int BLANK_LEADING   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_display_counter_if.slave   bus
);
    localparam int SCAN_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    w_inc_p;
    logic                    w_dec_p;
    logic                    w_clr_p;

    logic [4*NUM_DIGITS-1:0] r_count;
    logic                    r_wrap;
    logic [4*NUM_DIGITS-1:0] w_count_next;
    logic                    w_wrap_next;

    logic [SCAN_W-1:0]       r_scan_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_DIGITS-1:0]   r_an;
    seg_t                    r_seg;
    logic [IDX_W-1:0]        w_next_idx;
    bcd_digit_t              w_digit;
    logic                    w_lead_zero;
    seg_t                    w_seg_next;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_inc (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_inc), .level(), .press_pulse(w_inc_p)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_dec (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_dec), .level(), .press_pulse(w_dec_p)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_clr (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_clr), .level(), .press_pulse(w_clr_p)
    );

    // Next count: clear wins, inc+dec cancel, otherwise ripple BCD carry/borrow.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        logic ripple;
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        ripple       = 1'b1;
        if (w_clr_p) begin
            w_count_next = '0;
        end else if (w_inc_p && !w_dec_p) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (ripple) begin
                    if (r_count[4*i +: 4] == 4'd9) begin
                        w_count_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_count_next[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
            w_wrap_next = ripple;
        end else if (w_dec_p && !w_inc_p) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (ripple) begin
                    if (r_count[4*i +: 4] == 4'd0) begin
                        w_count_next[4*i +: 4] = 4'd9;
                    end else begin
                        w_count_next[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
            w_wrap_next = ripple;
        end
    end

    // Count register; wrap is high only in the cycle the wrapped value appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_wrap  <= w_wrap_next;
        end
    end

    // Select the digit for the next scan slot and decide whether it is a leading zero.
    always_comb begin
        logic upper_zero;
        w_next_idx  = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        w_digit     = '0;
        w_lead_zero = 1'b0;
        upper_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (r_count[4*i +: 4] == 4'd0);
            if (w_next_idx == IDX_W'(i)) begin
                w_digit     = r_count[4*i +: 4];
                w_lead_zero = upper_zero && (i != 0);
            end
        end
        w_seg_next = ((BLANK_LEADING != 0) && w_lead_zero) ? SEG_BLANK : seg_encode(w_digit);
    end

    // Dwell timer; at terminal count move to the next digit and latch its anode/segments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_an       <= ~NUM_DIGITS'(1);
            r_seg      <= SEG_0;
        end else if (r_scan_cnt == SCAN_W'(REFRESH_CYCLES - 1)) begin
            r_scan_cnt <= '0;
            r_idx      <= w_next_idx;
            r_an       <= ~(NUM_DIGITS'(1) << w_next_idx);
            r_seg      <= w_seg_next;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign bus.count_bcd = r_count;
    assign bus.wrap      = r_wrap;
    assign bus.an        = r_an;
    assign bus.seg       = r_seg;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Self-checking bench: directed scenarios plus random button traffic compared
// against a decimal-integer model of the counter and display.
module tb_bcd_display_counter;

    localparam int ND = 2;
    localparam int DB = 4;
    localparam int RF = 2;

    localparam logic [6:0] S_BLANK = 7'b1111111;

    logic clk;
    logic rst;

    bcd_display_counter_if #(.NUM_DIGITS(ND)) bus0 ();
    bcd_display_counter_if #(.NUM_DIGITS(ND)) bus1 ();

    assign bus1.btn_inc = bus0.btn_inc;
    assign bus1.btn_dec = bus0.btn_dec;
    assign bus1.btn_clr = bus0.btn_clr;

    bcd_display_counter #(
        .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF), .BLANK_LEADING(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    bcd_display_counter #(
        .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF), .BLANK_LEADING(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests   = 0;
    int n_fail    = 0;
    int wrap_seen = 0;
    int model_v   = 0;
    int max_v;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Count cycles on which the wrap pulse is high.
    always @(negedge clk) begin
        if (bus0.wrap === 1'b1) wrap_seen++;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Expected segments of digit idx for value v, with or without leading-zero blanking.
    function automatic logic [6:0] exp_seg(input int v, input int idx, input bit blank);
        if (blank && idx > 0 && v < pow10(idx)) return S_BLANK;
        return seg_tbl[(v / pow10(idx)) % 10];
    endfunction

    // op: 0 inc, 1 dec, 2 clr, 3 inc+dec, 4 clr+inc
    task automatic do_op(input int op, input int hold, input int rel, input string tag);
        int w0;
        int exp_w;
        w0    = wrap_seen;
        exp_w = 0;
        bus0.btn_inc = (op == 0 || op == 3 || op == 4);
        bus0.btn_dec = (op == 1 || op == 3);
        bus0.btn_clr = (op == 2 || op == 4);
        tick(hold);
        bus0.btn_inc = 1'b0;
        bus0.btn_dec = 1'b0;
        bus0.btn_clr = 1'b0;
        tick(rel);
        case (op)
            0: if (model_v == max_v) begin model_v = 0; exp_w = 1; end else model_v++;
            1: if (model_v == 0) begin model_v = max_v; exp_w = 1; end else model_v--;
            2, 4: model_v = 0;
            default: ;
        endcase
        check({tag, "_count"}, 32'(bus0.count_bcd), 32'(to_bcd(model_v)));
        check({tag, "_wrap"}, 32'(wrap_seen - w0), 32'(exp_w));
    endtask

    initial begin
        int prev_an;
        int idx0;
        bit found;
        int r;
        int op;

        max_v = pow10(ND) - 1;
        rst = 1'b1;
        bus0.btn_inc = 1'b0;
        bus0.btn_dec = 1'b0;
        bus0.btn_clr = 1'b0;
        tick(3);

        check("reset_count", 32'(bus0.count_bcd), 32'd0);
        check("reset_wrap", 32'(bus0.wrap), 32'd0);
        check("reset_an", 32'(bus0.an), 32'(2'b10));
        check("reset_seg", 32'(bus0.seg), 32'(seg_tbl[0]));
        check("reset_seg_blank_dut", 32'(bus1.seg), 32'(seg_tbl[0]));
        rst = 1'b0;
        tick(2);

        // Long hold gives exactly one step.
        bus0.btn_inc = 1'b1;
        tick(20);
        model_v = 1;
        check("hold20_count", 32'(bus0.count_bcd), 32'(to_bcd(model_v)));
        check("hold20_wrap", 32'(wrap_seen), 32'd0);
        bus0.btn_inc = 1'b0;
        tick(10);
        check("hold20_release", 32'(bus0.count_bcd), 32'(to_bcd(model_v)));

        // Glitchy press never stays high DB cycles in a row.
        foreach (seg_tbl[k]) begin end
        begin
            int pat [7] = '{1, 1, 1, 0, 1, 1, 1};
            for (int k = 0; k < 7; k++) begin
                bus0.btn_inc = pat[k][0];
                tick(1);
            end
        end
        bus0.btn_inc = 1'b0;
        tick(10);
        check("glitch_count", 32'(bus0.count_bcd), 32'(to_bcd(model_v)));
        do_op(0, 10, 10, "after_glitch");

        // Preload to all-9s, then wrap both ways.
        while (model_v != max_v) do_op(0, $urandom_range(8, 12), $urandom_range(9, 12), "preload");
        do_op(0, 9, 10, "wrap_up");
        do_op(1, 9, 10, "wrap_down");

        // Carry, borrow, coincident presses.
        do_op(2, 9, 10, "clear");
        repeat (19) do_op(0, 8, 9, "to19");
        do_op(0, 9, 10, "carry19");
        do_op(1, 9, 10, "borrow20");
        do_op(3, 9, 10, "inc_dec_same");
        do_op(0, 9, 10, "pre_clr_inc");
        do_op(4, 9, 10, "clr_inc_same");

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 4;
            do_op(op, $urandom_range(8, 14), $urandom_range(9, 13), "random");
        end

        // Display scan with value 07.
        do_op(2, 9, 10, "disp_clear");
        repeat (7) do_op(0, 8, 9, "disp_inc");
        check("disp_count_blank_dut", 32'(bus1.count_bcd), 32'(to_bcd(model_v)));
        prev_an = int'(bus1.an);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick(1);
            if (int'(bus1.an) != prev_an) found = 1'b1;
        end
        check("scan_advance_seen", 32'(found), 32'd1);
        idx0 = (bus1.an === 2'b10) ? 0 : 1;
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (idx0 + k / 2) % ND;
            check("scan_an_blank", 32'(bus1.an), 32'(~(2'b01 << idx) & 2'b11));
            check("scan_seg_blank", 32'(bus1.seg), 32'(exp_seg(model_v, idx, 1'b1)));
            check("scan_an_noblank", 32'(bus0.an), 32'(~(2'b01 << idx) & 2'b11));
            check("scan_seg_noblank", 32'(bus0.seg), 32'(exp_seg(model_v, idx, 1'b0)));
            tick(1);
        end

        // Asynchronous reset in the middle of a debounce with the button held.
        bus0.btn_inc = 1'b1;
        tick(3);
        #2 rst = 1'b1;
        #1;
        model_v = 0;
        check("async_rst_count", 32'(bus0.count_bcd), 32'd0);
        check("async_rst_wrap", 32'(bus0.wrap), 32'd0);
        check("async_rst_an", 32'(bus0.an), 32'(2'b10));
        check("async_rst_seg", 32'(bus0.seg), 32'(seg_tbl[0]));
        tick(2);
        rst = 1'b0;
        tick(DB + 3);
        check("rst_press_early", 32'(bus0.count_bcd), 32'd0);
        tick(1);
        model_v = 1;
        check("rst_press_latency", 32'(bus0.count_bcd), 32'(to_bcd(model_v)));
        bus0.btn_inc = 1'b0;
        tick(12);
        check("rst_press_release", 32'(bus0.count_bcd), 32'(to_bcd(model_v)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_counter.md
Name: bcd_display_counter

Overview:
- Parametrised multi-digit decimal (BCD) up/down counter driven by three raw push-buttons: increment, decrement and clear.
- Each button passes through a 2-flop synchroniser, a debouncer and a rising-edge detector, so one press equals exactly one count step.
- The count is shown on a time-multiplexed NUM_DIGITS-digit common-anode 7-segment display, with optional leading-zero blanking.
- Sits between the board buttons/display pins and the top level; replaces the single-digit button counter.

Parameters:
- NUM_DIGITS, 4: number of BCD digits and display anodes (1..8).
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a button level change (>=2).
- REFRESH_CYCLES, 100000: clock cycles each digit stays lit per scan (>=1).
- BLANK_LEADING, 0: 1 = blank leading zero digits; digit 0 is always shown.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- btn_inc  input  1  raw increment button, active-high, asynchronous to clk.
- btn_dec  input  1  raw decrement button, active-high, asynchronous.
- btn_clr  input  1  raw clear button, active-high, asynchronous.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  output  NUM_DIGITS  digit anodes, active-low one-hot, registered; bit 0 = least significant digit.
- count_bcd  output  4*NUM_DIGITS  current count; nibble i = digit i; registered.
- wrap  output  1  one-cycle pulse on a wrap-around step.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - rst asynchronously forces: count_bcd=0, wrap=0, an=~1 (digit 0 on), seg=7'b1000000, scan counter and index 0, all synchroniser/debounce/edge state 0.
- Conditioning, per button, independent:
  - 2-flop synchroniser feeds a stable-level register.
  - The debounce counter resets to 0 whenever the synced input equals the stable level. Otherwise it increments.
  - On reaching DEBOUNCE_CYCLES, the stable level takes the synced value and the counter clears.
  - A single glitch cycle back to the stable level restarts the count.
  - Press pulse = stable level rising edge, registered: exactly 1 cycle, once per accepted press, regardless of hold time.
  - Releases produce no pulse.
- Count update, on the clock edge after the press pulse. Priority, same cycle:
  - clr: count=0, no wrap.
  - inc and dec together: no change.
  - inc: BCD increment with ripple carry across digits (digit 9 -> 0, carry into next). All-9s -> all-0, wrap=1.
  - dec: BCD decrement with borrow (digit 0 -> 9). All-0 -> all-9s, wrap=1.
  - Each nibble is always 0..9; no binary-to-BCD conversion.
- wrap is asserted in the same cycle count_bcd takes the wrapped value, and low otherwise.
- Latency: synced input stable for DEBOUNCE_CYCLES -> stable level, +1 -> pulse, +1 -> count_bcd. About DEBOUNCE_CYCLES+4 cycles from pin edge.
- Display scan:
  - Scan counter counts 0..REFRESH_CYCLES-1. At terminal count the digit index advances, NUM_DIGITS-1 wraps to 0.
  - an and seg are updated in the same cycle from the new index: an = ~(1<<index), seg = encode(count_bcd digit[index]).
  - Digit shown is sampled from the current count_bcd at update time; a count change mid-dwell appears at that digit's next dwell.
- Encoding (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Blanking (BLANK_LEADING=1): digit i>0 is blank if it and all higher digits are 0. The anode is still driven.
- Reset mid-operation: a button held through rst deassertion is accepted as a new press after DEBOUNCE_CYCLES; this is intended.

Decomposition:
- Shared package holds:
  - SEG_0..SEG_9 and SEG_BLANK constants.
  - A bcd_digit_t 4-bit typedef.
  - The seg-encode function.
- One sub-module, btn_conditioner (param DEBOUNCE_CYCLES; ports clk, rst, btn_raw, level, press_pulse), instantiated three times.
- BCD arithmetic and scan logic stay in the top module.

Test Plan (NUM_DIGITS=2, DEBOUNCE_CYCLES=4, REFRESH_CYCLES=2):
- Reset, then hold btn_inc for 20 cycles -> count_bcd=0x01 exactly once; no further steps while held; wrap stays 0.
- btn_inc glitch pattern 1,1,1,0,1,1,1 cycles -> no count change. Then held 10 cycles -> count_bcd increments by exactly 1.
- Preload 0x99 via 99 presses, then one inc press -> count_bcd=0x00 with wrap=1 for one cycle. From 0x00, a dec press -> 0x99, wrap pulse.
- 0x19 inc -> 0x20 (carry). 0x20 dec -> 0x19 (borrow). btn_inc and btn_dec pulses coincident -> unchanged. Coincident clr and inc -> 0x00.
- count_bcd=0x07, BLANK_LEADING=1 -> an alternates 10 (seg=1111000) / 01 (seg=1111111) every 2 cycles. With BLANK_LEADING=0, digit 1 shows 1000000.
- rst asserted mid-debounce with btn_inc held -> outputs return to reset values immediately (asynchronous). After release of rst, count=0x01 after DEBOUNCE_CYCLES+4 cycles.
